knap_enum: RTL and testbench
============================

KNAP_ENUM -- requirements
Module: knap_enum

Interface
REQ-001 Parameter N_ITEMS, default 24: number of item-select bits driven to the downstream feasibility checker.
REQ-002 Parameter CNT_W, default N_ITEMS+1: width of the solution counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a search; honoured only in IDLE or DONE.
REQ-006 abort  input  1  terminates an active search.
REQ-007 cand  output  N_ITEMS  current candidate selection; bit i drives item i of the checker.
REQ-008 valid_in  input  1  combinational checker verdict for the cand presented in the same cycle.
REQ-009 busy  output  1  high while in SCAN.
REQ-010 done  output  1  high while in DONE.
REQ-011 found  output  1  at least one feasible candidate was seen in the last completed search.
REQ-012 solution  output  N_ITEMS  first feasible candidate found, in ascending cand order.
REQ-013 sol_count  output  CNT_W  number of feasible candidates seen; present only with KNAP_ENUM_COUNT_EN.

Function
REQ-014 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-015 IDLE or DONE with start=1: next state SCAN; cand, found, solution and sol_count cleared to 0.
REQ-016 SCAN: each cycle, sample valid_in against the registered cand, then increment cand by 1; throughput 1 candidate per cycle, no bubbles.
REQ-017 valid_in=1 with found=0: solution<=cand and found<=1 in the same edge; later hits do not overwrite solution.
REQ-018 Without KNAP_ENUM_COUNT_EN, a hit SHALL move SCAN to DONE; cand holds the hit value.
REQ-019 A sample at cand = all-ones SHALL move SCAN to DONE whatever the verdict; cand SHALL NOT wrap.
REQ-020 A hit at cand = all-ones SHALL set found=1 and solution = all-ones.
REQ-021 abort=1 in SCAN: next state IDLE, found and solution cleared; abort has priority over a same-cycle hit; abort outside SCAN is ignored.
REQ-022 start during SCAN is ignored; start and abort together in IDLE/DONE: start wins.
REQ-023 DONE holds found, solution and sol_count stable until the next start.
REQ-024 Worst-case latency from start to done is 2^N_ITEMS + 1 cycles.

Reset
REQ-025 rst=1 forces IDLE immediately, including mid-search; cand, found, solution and sol_count return to 0; busy=0, done=0.
REQ-026 The first start after rst deassertion is honoured on the next clock edge.

Configuration
REQ-027 Macro KNAP_ENUM_COUNT_EN defined: sol_count exists; every hit increments it, saturating at all-ones; a hit does not end the search; SCAN ends only at all-ones or abort.
REQ-028 KNAP_ENUM_COUNT_EN undefined: no sol_count port and no counter logic; the search stops at the first hit (REQ-018).

Structure
REQ-029 Package knap_pkg holds the N_ITEMS default, the FSM state enum typedef and the CNT_W derivation.
REQ-030 No sub-module; the feasibility checker is instantiated outside the block, beside it, and connected through cand and valid_in.

Verification (N_ITEMS=4 unless stated)
REQ-031 Checker true only for cand=4'b0101; start -> busy for 6 cycles, then done=1, found=1, solution=4'b0101.
REQ-032 Checker always false; start -> 16 samples, then done=1, found=0, cand=4'hF, no wrap to 0.
REQ-033 Checker true only for 4'hF -> found=1, solution=4'hF, done after 16 samples.
REQ-034 abort at cand=3 while that candidate is feasible -> IDLE next cycle, found=0, solution=0.
REQ-035 rst pulsed asynchronously mid-scan at cand=7 -> outputs 0 before the next clock edge; a following start restarts from cand=0.
REQ-036 With KNAP_ENUM_COUNT_EN, checker true for 4'h2, 4'h9 and 4'hC -> sol_count=3, solution=4'h2, done after 16 samples.

Source files
------------

// File: rtl/knap_pkg.sv
// Shared definitions for the knap_enum candidate enumerator: default item
// count, FSM state encoding and the solution-counter width derivation.
package knap_pkg;

   localparam int N_ITEMS_DEF = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } knap_state_e;

   // Counter is one bit wider than the item count so 2^N_ITEMS hits fit.
   function automatic int cnt_width(input int n_items);
      return n_items + 1;
   endfunction

endpackage

// File: rtl/knap_enum.sv
// Exhaustive subset enumerator: walks cand from 0 to all-ones, one candidate per
// cycle, and records the first feasible one. Optional macro KNAP_ENUM_COUNT_EN
// adds a saturating hit counter (sol_count, CNT_W) and scans the whole space.
//
// Handshake: start is a one-cycle pulse accepted only in IDLE/DONE (start beats
// abort there); abort is acted on only in SCAN and beats a same-cycle hit;
// valid_in is the checker's combinational verdict on the cand of that cycle.
module knap_enum
   import knap_pkg::*;
#(
   parameter int N_ITEMS = N_ITEMS_DEF
`ifdef KNAP_ENUM_COUNT_EN
   ,
   parameter int CNT_W   = cnt_width(N_ITEMS)
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic [N_ITEMS-1:0] cand,
   input  logic               valid_in,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic [N_ITEMS-1:0] solution,
`ifdef KNAP_ENUM_COUNT_EN
   output logic [CNT_W-1:0]   sol_count,
`endif
   output knap_state_e        dbg_state
);

   localparam logic [N_ITEMS-1:0] CAND_MAX = '1;

   knap_state_e        state_q, state_d;
   logic [N_ITEMS-1:0] cand_q, cand_d;
   logic               found_q, found_d;
   logic [N_ITEMS-1:0] sol_q, sol_d;
   logic               last_cand;
   logic               first_hit;

`ifdef KNAP_ENUM_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   assign last_cand = (cand_q == CAND_MAX);
   assign first_hit = valid_in && !found_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cand_q  <= '0;
         found_q <= 1'b0;
         sol_q   <= '0;
`ifdef KNAP_ENUM_COUNT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         found_q <= found_d;
         sol_q   <= sol_d;
`ifdef KNAP_ENUM_COUNT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      found_d = found_q;
      sol_d   = sol_q;
`ifdef KNAP_ENUM_COUNT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_SCAN;
               cand_d  = '0;
               found_d = 1'b0;
               sol_d   = '0;
`ifdef KNAP_ENUM_COUNT_EN
               cnt_d   = '0;
`endif
            end
         end
         ST_SCAN: begin
            if (abort) begin
               state_d = ST_IDLE;
               found_d = 1'b0;
               sol_d   = '0;
            end else begin
               if (first_hit) begin
                  found_d = 1'b1;
                  sol_d   = cand_q;
               end
`ifdef KNAP_ENUM_COUNT_EN
               if (valid_in && (cnt_q != CNT_MAX))
                  cnt_d = cnt_q + 1'b1;
               if (last_cand)
                  state_d = ST_DONE;
               else
                  cand_d = cand_q + 1'b1;
`else
               // cand is frozen on the terminating sample so it shows the hit.
               if (valid_in || last_cand)
                  state_d = ST_DONE;
               else
                  cand_d = cand_q + 1'b1;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cand      = cand_q;
   assign busy      = (state_q == ST_SCAN);
   assign done      = (state_q == ST_DONE);
   assign found     = found_q;
   assign solution  = sol_q;
   assign dbg_state = state_q;
`ifdef KNAP_ENUM_COUNT_EN
   assign sol_count = cnt_q;
`endif

endmodule

// File: tb/tb_knap_enum.sv
// Directed bench for knap_enum with N_ITEMS=4; the feasibility checker is a
// 16-bit mask indexed by cand.
module tb_knap_enum;
   import knap_pkg::*;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic         valid_in;
   logic [N-1:0] cand;
   logic [N-1:0] solution;
   logic         busy;
   logic         done;
   logic         found;
   knap_state_e  dbg_state;
`ifdef KNAP_ENUM_COUNT_EN
   logic [N:0]   sol_count;
`endif
   logic [15:0]  feas;

   int total = 0;
   int bad   = 0;
   int n;

   // clock / reset
   always #5 clk = ~clk;

   knap_enum #(.N_ITEMS(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .cand      (cand),
      .valid_in  (valid_in),
      .busy      (busy),
      .done      (done),
      .found     (found),
      .solution  (solution),
`ifdef KNAP_ENUM_COUNT_EN
      .sol_count (sol_count),
`endif
      .dbg_state (dbg_state)
   );

   assign valid_in = feas[cand];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic wait_cand(input logic [N-1:0] k);
      int g;
      g = 0;
      while (cand !== k && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("wait_cand", 32'(cand), 32'(k));
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      feas  = 16'h0000;
      #12;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_found", 32'(found), 0);
      check("rst_sol", 32'(solution), 0);
      check("rst_cand", 32'(cand), 0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;

      // single feasible candidate 5
      feas = 16'h0020;
      do_start();
      check("first_start_busy", 32'(busy), 1);
      count_busy(n);
      check("hit5_cycles", n, 6);
      check("hit5_done", 32'(done), 1);
      check("hit5_found", 32'(found), 1);
      check("hit5_sol", 32'(solution), 5);
      check("hit5_cand", 32'(cand), 5);
      check("hit5_state", 32'(dbg_state), 32'(ST_DONE));

      // abort outside SCAN is ignored
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_done_done", 32'(done), 1);
      check("abort_done_found", 32'(found), 1);
      check("abort_done_sol", 32'(solution), 5);

      // nothing feasible, start mid-scan ignored, no wrap
      feas = 16'h0000;
      do_start();
      wait_cand(4'd6);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_scan_cand", 32'(cand), 7);
      check("start_in_scan_busy", 32'(busy), 1);
      count_busy(n);
      check("none_cycles_rest", n, 9);
      check("none_done", 32'(done), 1);
      check("none_found", 32'(found), 0);
      check("none_cand", 32'(cand), 15);
      repeat (3) @(negedge clk);
      check("none_hold_cand", 32'(cand), 15);
      check("none_hold_done", 32'(done), 1);

      // hit only at all-ones
      feas = 16'h8000;
      do_start();
      count_busy(n);
      check("hitF_cycles", n, 16);
      check("hitF_found", 32'(found), 1);
      check("hitF_sol", 32'(solution), 15);
      check("hitF_done", 32'(done), 1);

      // start and abort together in DONE: start wins; then abort on a hit
      feas = 16'h0008;
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", 32'(busy), 1);
      check("start_abort_cand", 32'(cand), 0);
      check("start_abort_found", 32'(found), 0);
      wait_cand(4'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_found", 32'(found), 0);
      check("abort_sol", 32'(solution), 0);

      // asynchronous reset mid-scan
      feas = 16'h0000;
      do_start();
      wait_cand(4'd7);
      #2 rst = 1'b1;
      #1;
      check("arst_cand", 32'(cand), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_done", 32'(done), 0);
      check("arst_found", 32'(found), 0);
      check("arst_sol", 32'(solution), 0);
      #1 rst = 1'b0;
      do_start();
      check("arst_restart_cand", 32'(cand), 0);
      check("arst_restart_busy", 32'(busy), 1);
      count_busy(n);
      check("arst_restart_cycles", n, 16);

      // several feasible candidates: 2, 9, 12
      feas = 16'h1204;
      do_start();
      count_busy(n);
`ifdef KNAP_ENUM_COUNT_EN
      check("multi_cycles", n, 16);
      check("multi_count", 32'(sol_count), 3);
      check("multi_cand", 32'(cand), 15);
`else
      check("multi_cycles", n, 3);
      check("multi_cand", 32'(cand), 2);
`endif
      check("multi_sol", 32'(solution), 2);
      check("multi_found", 32'(found), 1);
      check("multi_done", 32'(done), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
